// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Matrix-keypad scanner. It drives one column at a time and samples the
// synchronised row lines on a divided scan tick. A key is confirmed only
// after a debounced press, and a one-cycle key_valid pulse reports its
// {row_idx, col_idx} code. While a key is held, scanning stops on that
// column until the release has been debounced.
//
// Optional feature macro: KEY_REPEAT_EN
//   When defined, holding a key produces extra key_valid pulses.
//   The first pulse comes REPEAT_DELAY ticks after confirm, and later
//   pulses follow every REPEAT_RATE ticks.
//   When undefined, the repeat logic is absent and each press gives
//   exactly one pulse.
//
// Ports
//   clk        in   1            system clock
//   reset      in   1            asynchronous, active-low reset
//   row_keys   in   NUM_ROWS     raw row inputs, active-high, asynchronous
//   col_keys   out  NUM_COLS     one-hot column drive (registered)
//   key_code   out  RW+CW        {row_idx, col_idx} of the confirmed key
//   key_valid  out  1            one-cycle pulse on a confirmed press (or repeat)
//   key_held   out  1            high from confirm until the release is debounced
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int NUM_COLS       = 4,
    parameter int NUM_ROWS       = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 3,
    parameter int REPEAT_DELAY   = 8,
    parameter int REPEAT_RATE    = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_ROWS-1:0]                           row_keys,
    output logic [NUM_COLS-1:0]                           col_keys,
    output logic [$clog2(NUM_ROWS)+$clog2(NUM_COLS)-1:0]  key_code,
    output logic                                          key_valid,
    output logic                                          key_held
);

    localparam int CW = $clog2(NUM_COLS);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int VW = $clog2(SCAN_DIV);
    localparam int DW = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;

    if (NUM_COLS < 2 || NUM_ROWS < 2 || SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 ||
        REPEAT_RATE < 1 || REPEAT_DELAY < REPEAT_RATE) begin : g_bad_params
        $error("keypad_scanner: invalid parameter set");
    end

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Index of the lowest set row. When several rows are active, the lowest one wins.
    function automatic logic [RW-1:0] lowest_row(input logic [NUM_ROWS-1:0] pat);
        logic [RW-1:0] idx;
        idx = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (pat[i]) begin
                idx = RW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot column drive pattern for a column index.
    function automatic logic [NUM_COLS-1:0] col_onehot(input logic [CW-1:0] idx);
        return {{(NUM_COLS-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [NUM_ROWS-1:0] r_sync1;
    logic [NUM_ROWS-1:0] r_rows_s;
    logic [VW-1:0]       r_div;
    logic                w_tick;
    state_t              r_state;
    logic [NUM_ROWS-1:0] r_pat;
    logic [DW-1:0]       r_cnt;
    logic                w_cnt_done;
    logic [CW-1:0]       r_col_idx;
    logic [CW-1:0]       w_col_next;
    logic [NUM_COLS-1:0] r_col_keys;
    logic [RW+CW-1:0]    r_key_code;
    logic                r_key_valid;
    logic                r_key_held;

`ifdef KEY_REPEAT_EN
    localparam int PW = $clog2(REPEAT_DELAY + 1);
    logic [PW-1:0] r_rep;
    logic          w_rep_fire;
    assign w_rep_fire = ((int'(r_rep) + 1) == REPEAT_DELAY);
`endif

    assign w_tick     = (r_div == VW'(SCAN_DIV - 1));
    // The tick that takes the count to DEBOUNCE_TICKS-1 finishes the debounce.
    assign w_cnt_done = ((int'(r_cnt) + 1) >= (DEBOUNCE_TICKS - 1));

    // Next column index, wrapping from the last column back to column 0.
    always_comb begin
        if (r_col_idx == CW'(NUM_COLS - 1)) begin
            w_col_next = '0;
        end else begin
            w_col_next = r_col_idx + CW'(1'b1);
        end
    end

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= '0;
            r_rows_s <= '0;
        end else begin
            r_sync1  <= row_keys;
            r_rows_s <= r_sync1;
        end
    end

    // Scan-tick divider: the count wraps at SCAN_DIV-1, which is also the tick cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + VW'(1'b1);
        end
    end

    // Scanner FSM and its registered outputs. All state changes happen on the tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_SCAN;
            r_pat       <= '0;
            r_cnt       <= '0;
            r_col_idx   <= '0;
            r_col_keys  <= col_onehot('0);
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
            r_rep       <= '0;
`endif
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_SCAN: begin
                        if (r_rows_s != '0) begin
                            r_pat   <= r_rows_s;
                            r_cnt   <= '0;
                            r_state <= ST_DEBOUNCE;
                        end else begin
                            r_col_idx  <= w_col_next;
                            r_col_keys <= col_onehot(w_col_next);
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (r_rows_s == r_pat) begin
                            if (w_cnt_done) begin
                                r_state     <= ST_HELD;
                                r_cnt       <= '0;
                                r_key_code  <= {lowest_row(r_pat), r_col_idx};
                                r_key_held  <= 1'b1;
                                r_key_valid <= 1'b1;
`ifdef KEY_REPEAT_EN
                                r_rep       <= '0;
`endif
                            end else begin
                                r_cnt <= r_cnt + DW'(1'b1);
                            end
                        end else begin
                            // The pattern changed, so drop the candidate and keep this column.
                            r_state <= ST_SCAN;
                        end
                    end
                    ST_HELD: begin
                        if (r_rows_s == '0) begin
                            r_state <= ST_RELEASE;
                            r_cnt   <= '0;
`ifdef KEY_REPEAT_EN
                            r_rep   <= '0;
                        end else if (w_rep_fire) begin
                            // Reload so that the next repeat comes REPEAT_RATE ticks later.
                            r_key_valid <= 1'b1;
                            r_rep       <= PW'(REPEAT_DELAY - REPEAT_RATE);
                        end else begin
                            r_rep <= r_rep + PW'(1'b1);
`endif
                        end
                    end
                    ST_RELEASE: begin
                        if (r_rows_s == '0) begin
                            if (w_cnt_done) begin
                                r_state    <= ST_SCAN;
                                r_cnt      <= '0;
                                r_key_held <= 1'b0;
                                r_col_idx  <= w_col_next;
                                r_col_keys <= col_onehot(w_col_next);
                            end else begin
                                r_cnt <= r_cnt + DW'(1'b1);
                            end
                        end else begin
                            // A bounce during release: the key is still held, with no new pulse.
                            r_state <= ST_HELD;
                            r_cnt   <= '0;
`ifdef KEY_REPEAT_EN
                            r_rep   <= '0;
`endif
                        end
                    end
                    default: begin
                        r_state <= ST_SCAN;
                    end
                endcase
            end
        end
    end

    assign col_keys  = r_col_keys;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with NUM_COLS=4, NUM_ROWS=4, SCAN_DIV=4, DEBOUNCE_TICKS=3.
// Inputs change and outputs are sampled on falling edges. A "tick" below means
// four clocks: one scan tick of the DUT counted from reset release.
module tb_keypad_scanner;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic [3:0] row_keys = 4'b0000;
    logic [3:0] col_keys;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int n_checks   = 0;
    int n_errors   = 0;
    int pulse_cnt  = 0;
    int pulse_base = 0;

`ifdef KEY_REPEAT_EN
    localparam int EXP_HOLD_PULSES = 5;
`else
    localparam int EXP_HOLD_PULSES = 1;
`endif

    keypad_scanner #(
        .NUM_COLS       (4),
        .NUM_ROWS       (4),
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (3),
        .REPEAT_DELAY   (8),
        .REPEAT_RATE    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_keys  (row_keys),
        .col_keys  (col_keys),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Count the cycles in which key_valid is high, using the value from before the edge.
    always @(posedge clk) begin
        if (key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic ticks(input int n);
        repeat (4 * n) @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_col;

        // 1: reset state, then the free-running column scan
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_col", col_keys, 4'b0001);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        chk("rst_code", key_code, 4'h0);
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ticks(1);
            exp_col = 4'b0001 << (i % 4);
            chk("scan_col", col_keys, exp_col);
        end
        ticks(1);
        chk("scan_col_1", col_keys, 4'b0010);

        // 2: stable row 2 on column 1 -> code 9
        pulse_base = pulse_cnt;
        row_keys = 4'b0100;
        ticks(2);
        chk("deb_valid_lo", key_valid, 1'b0);
        chk("deb_held_lo", key_held, 1'b0);
        chk("deb_col", col_keys, 4'b0010);
        ticks(1);
        chk("cfm_valid", key_valid, 1'b1);
        chk("cfm_code", key_code, 4'h9);
        chk("cfm_held", key_held, 1'b1);
        chk("cfm_col", col_keys, 4'b0010);
        ticks(2);
        chk("hold_held", key_held, 1'b1);
        chk("hold_col", col_keys, 4'b0010);
        chk("hold_pulses", pulse_cnt - pulse_base, 1);

        // 4: release, with a one-tick bounce back to HELD, then a clean release
        row_keys = 4'b0000;
        ticks(1);
        chk("rel_held", key_held, 1'b1);
        row_keys = 4'b0100;
        ticks(1);
        chk("bounce_held", key_held, 1'b1);
        row_keys = 4'b0000;
        ticks(2);
        chk("rel2_held", key_held, 1'b1);
        chk("rel2_col", col_keys, 4'b0010);
        ticks(1);
        chk("relx_held", key_held, 1'b0);
        chk("relx_col", col_keys, 4'b0100);
        chk("relx_pulses", pulse_cnt - pulse_base, 1);

        // 3: one-tick press dropped during DEBOUNCE -> no pulse, column kept
        pulse_base = pulse_cnt;
        row_keys = 4'b0001;
        ticks(1);
        row_keys = 4'b0000;
        ticks(1);
        chk("glitch_col", col_keys, 4'b0100);
        chk("glitch_held", key_held, 1'b0);
        ticks(1);
        chk("glitch_adv", col_keys, 4'b1000);
        chk("glitch_pulses", pulse_cnt - pulse_base, 0);

        // 5: rows 1 and 3 on column 3 -> lowest row wins, code 7
        pulse_base = pulse_cnt;
        row_keys = 4'b1010;
        ticks(3);
        chk("multi_valid", key_valid, 1'b1);
        chk("multi_code", key_code, 4'h7);
        chk("multi_held", key_held, 1'b1);
        chk("multi_col", col_keys, 4'b1000);
        row_keys = 4'b0000;
        ticks(3);
        chk("wrap_held", key_held, 1'b0);
        chk("wrap_col", col_keys, 4'b0001);
        chk("multi_pulses", pulse_cnt - pulse_base, 1);
        ticks(1);
        row_keys = 4'b0001;
        ticks(1);
        chk("pre_rst_col", col_keys, 4'b0010);
        chk("pre_rst_code", key_code, 4'h7);
        // Assert reset between clock edges: the outputs must clear without waiting for clk.
        #2;
        reset = 1'b0;
        #1;
        chk("async_col", col_keys, 4'b0001);
        chk("async_code", key_code, 4'h0);
        chk("async_held", key_held, 1'b0);
        chk("async_valid", key_valid, 1'b0);
        row_keys = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // 6: long hold on row 0 / column 1 -> one pulse, or five pulses with auto-repeat
        ticks(1);
        chk("r6_col", col_keys, 4'b0010);
        pulse_base = pulse_cnt;
        row_keys = 4'b0001;
        ticks(3);
        chk("r6_valid", key_valid, 1'b1);
        chk("r6_code", key_code, 4'h1);
        ticks(21);
        chk("r6_held", key_held, 1'b1);
        chk("r6_code_stable", key_code, 4'h1);
        chk("r6_col_frozen", col_keys, 4'b0010);
        row_keys = 4'b0000;
        ticks(3);
        chk("r6_rel_held", key_held, 1'b0);
        chk("r6_rel_col", col_keys, 4'b0100);
        chk("r6_pulses", pulse_cnt - pulse_base, EXP_HOLD_PULSES);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
